reg_file: RTL and testbench

- 32 x 32-bit integer register file for the single-cycle RISC-V datapath.
- Sits at the other end of the ALU operand/result interface:
  - sources op_a (rs1) and op_b (rs2) for the ALU;
  - accepts the writeback value (ALU result or load data) into rd at the clock edge.
- Has a third read-only debug port for bench and board inspection.

---
 rtl/rv_pkg.sv | 15 +
 rtl/reg_file_rd_port.sv | 24 ++
 rtl/reg_file.sv | 73 +++++++
 tb/tb_reg_file.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared widths, register indices and word type for the RISC-V datapath
package rv_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_AW-1:0] REG_RA   = 5'd1;
  localparam logic [REG_AW-1:0] REG_SP   = 5'd2;

  localparam logic [XLEN-1:0] SP_INIT_DEF = 32'h0000_03FC;

  typedef logic [XLEN-1:0] word_t;

endpackage

// File: rtl/reg_file_rd_port.sv
// rtl/reg_file_rd_port.sv - one combinational read port: index mux, x0 forcing, optional write bypass
module reg_file_rd_port #(
  parameter int XLEN   = rv_pkg::XLEN,
  parameter int NREGS  = 32,
  parameter int BYPASS = 0
) (
  input  logic [XLEN-1:0]          regs [NREGS],
  input  logic [rv_pkg::REG_AW-1:0] addr,
  input  logic                     byp_valid,
  input  logic [rv_pkg::REG_AW-1:0] byp_addr,
  input  logic [XLEN-1:0]          byp_data,
  output logic [XLEN-1:0]          data
);

  always_comb begin
    data = regs[addr];
    if (addr == rv_pkg::REG_ZERO) begin
      data = '0;
    end else if ((BYPASS != 0) && byp_valid && (byp_addr == addr)) begin
      data = byp_data;
    end
  end

endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 32 x XLEN integer register file with two ALU read ports and a debug read port
module reg_file #(
  parameter int                 XLEN    = rv_pkg::XLEN,
  parameter int                 NREGS   = 32,
  parameter logic [XLEN-1:0]    SP_INIT = rv_pkg::SP_INIT_DEF,
  parameter int                 BYPASS  = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      reg_write,
  input  logic [rv_pkg::REG_AW-1:0] rd_addr,
  input  logic [XLEN-1:0]           rd_data,
  input  logic [rv_pkg::REG_AW-1:0] rs1_addr,
  input  logic [rv_pkg::REG_AW-1:0] rs2_addr,
  output logic [XLEN-1:0]           rs1_data,
  output logic [XLEN-1:0]           rs2_data,
  input  logic [rv_pkg::REG_AW-1:0] dbg_addr,
  output logic [XLEN-1:0]           dbg_data
);

  logic [XLEN-1:0] regs [1:NREGS-1];
  logic [XLEN-1:0] regs_view [NREGS];
  logic            wr_en;

  assign wr_en = reg_write && !rst && (rd_addr != rv_pkg::REG_ZERO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < NREGS; i++) begin
        regs[i] <= (i == int'(rv_pkg::REG_SP)) ? SP_INIT : '0;
      end
    end else if (wr_en) begin
      regs[rd_addr] <= rd_data;
    end
  end

  // x0 has no storage; slot 0 of the view is a constant zero
  always_comb begin
    regs_view[0] = '0;
    for (int i = 1; i < NREGS; i++) begin
      regs_view[i] = regs[i];
    end
  end

  reg_file_rd_port #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(BYPASS)) u_rs1 (
    .regs      (regs_view),
    .addr      (rs1_addr),
    .byp_valid (wr_en),
    .byp_addr  (rd_addr),
    .byp_data  (rd_data),
    .data      (rs1_data)
  );

  reg_file_rd_port #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(BYPASS)) u_rs2 (
    .regs      (regs_view),
    .addr      (rs2_addr),
    .byp_valid (wr_en),
    .byp_addr  (rd_addr),
    .byp_data  (rd_data),
    .data      (rs2_data)
  );

  // debug view always shows committed state
  reg_file_rd_port #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(0)) u_dbg (
    .regs      (regs_view),
    .addr      (dbg_addr),
    .byp_valid (1'b0),
    .byp_addr  (rv_pkg::REG_ZERO),
    .byp_data  ('0),
    .data      (dbg_data)
  );

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - table-driven scoreboard bench running unbypassed and bypassed register files side by side
module tb_reg_file;

  localparam logic [31:0] SP = 32'h0000_03FC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reg_write = 1'b0;
  logic [4:0]  rd_addr = '0;
  logic [31:0] rd_data = '0;
  logic [4:0]  rs1_addr = '0;
  logic [4:0]  rs2_addr = '0;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] rs1_0, rs2_0, dbg_0, rs1_1, rs2_1, dbg_1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  reg_file #(.BYPASS(0)) dut0 (
    .clk(clk), .rst(rst), .reg_write(reg_write), .rd_addr(rd_addr), .rd_data(rd_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_0), .rs2_data(rs2_0),
    .dbg_addr(dbg_addr), .dbg_data(dbg_0)
  );

  reg_file #(.BYPASS(1)) dut1 (
    .clk(clk), .rst(rst), .reg_write(reg_write), .rd_addr(rd_addr), .rd_data(rd_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_1), .rs2_data(rs2_1),
    .dbg_addr(dbg_addr), .dbg_data(dbg_1)
  );

  typedef struct {
    logic        we;
    logic [4:0]  rd_a;
    logic [31:0] rd_d;
    logic [4:0]  rs1_a;
    logic [4:0]  rs2_a;
    logic [4:0]  dbg_a;
    logic [31:0] e_rs1_0;
    logic [31:0] e_rs1_1;
    logic [31:0] e_rs2_0;
    logic [31:0] e_rs2_1;
    logic [31:0] e_dbg;
  } vec_t;

  vec_t sb[$];
  vec_t vecs[9];

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %h want %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reg_write = v.we;
    rd_addr   = v.rd_a;
    rd_data   = v.rd_d;
    rs1_addr  = v.rs1_a;
    rs2_addr  = v.rs2_a;
    dbg_addr  = v.dbg_a;
    sb.push_back(v);
  endtask

  task automatic sample(input string nm, input int idx);
    vec_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s[%0d]: scoreboard empty", nm, idx);
    end else begin
      e = sb.pop_front();
      chk({nm, "_rs1_b0"}, idx, rs1_0, e.e_rs1_0);
      chk({nm, "_rs1_b1"}, idx, rs1_1, e.e_rs1_1);
      chk({nm, "_rs2_b0"}, idx, rs2_0, e.e_rs2_0);
      chk({nm, "_rs2_b1"}, idx, rs2_1, e.e_rs2_1);
      chk({nm, "_dbg_b0"}, idx, dbg_0, e.e_dbg);
      chk({nm, "_dbg_b1"}, idx, dbg_1, e.e_dbg);
    end
  endtask

  // one vector per cycle: drive after the falling edge, check before the rising edge
  task automatic apply(input vec_t v, input string nm, input int idx);
    @(negedge clk);
    drive(v);
    #1;
    sample(nm, idx);
  endtask

  function automatic vec_t mk(input logic we, input logic [4:0] rda, input logic [31:0] rdd,
                              input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad,
                              input logic [31:0] r10, input logic [31:0] r11,
                              input logic [31:0] r20, input logic [31:0] r21, input logic [31:0] d);
    vec_t v;
    v.we = we; v.rd_a = rda; v.rd_d = rdd; v.rs1_a = a1; v.rs2_a = a2; v.dbg_a = ad;
    v.e_rs1_0 = r10; v.e_rs1_1 = r11; v.e_rs2_0 = r20; v.e_rs2_1 = r21; v.e_dbg = d;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    logic [31:0] w;

    vecs[0] = mk(1, 5, 32'hDEAD_BEEF, 5, 5, 5, 0, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 0);
    vecs[1] = mk(0, 0, 0, 5, 5, 5, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    vecs[2] = mk(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[3] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[4] = mk(1, 7, 32'h1, 7, 2, 7, 0, 32'h1, SP, SP, 0);
    vecs[5] = mk(1, 7, 32'h2, 7, 7, 7, 32'h1, 32'h2, 32'h1, 32'h2, 32'h1);
    vecs[6] = mk(0, 0, 0, 7, 5, 7, 32'h2, 32'h2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h2);
    vecs[7] = mk(1, 2, 32'h55, 2, 3, 2, SP, 32'h55, 0, 0, SP);
    vecs[8] = mk(0, 0, 0, 2, 0, 31, 32'h55, 32'h55, 0, 0, 0);

    // power-on reset held across two edges
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // dirty a few registers, then assert reset mid-cycle with no clock edge
    apply(mk(1, 2, 32'hAAAA_0002, 2, 5, 31, SP, 32'hAAAA_0002, 0, 0, 0), "pre", 0);
    apply(mk(1, 5, 32'h5555_0005, 2, 5, 31, 32'hAAAA_0002, 32'hAAAA_0002, 0, 32'h5555_0005, 0), "pre", 1);
    apply(mk(1, 31, 32'h3131_3131, 2, 5, 31, 32'hAAAA_0002, 32'hAAAA_0002, 32'h5555_0005, 32'h5555_0005, 0), "pre", 2);
    @(negedge clk);
    drive(mk(0, 0, 0, 2, 5, 31, SP, SP, 0, 0, 0));
    #2 rst = 1'b1;
    #1 sample("async_rst", 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) apply(vecs[i], "vec", i);

    // reset held across a write edge: the write to x2 must be lost
    @(negedge clk);
    drive(mk(1, 2, 32'h1234, 2, 5, 31, SP, SP, 0, 0, 0));
    #1 rst = 1'b1;
    #1 sample("rst_wr", 0);
    @(posedge clk);
    #1;
    drive(mk(1, 2, 32'h1234, 2, 2, 2, SP, SP, SP, SP, SP));
    #1 sample("rst_wr", 1);
    @(negedge clk);
    rst = 1'b0;
    drive(mk(1, 2, 32'hABCD, 2, 2, 2, SP, 32'hABCD, SP, 32'hABCD, SP));
    #1 sample("rst_wr", 2);
    apply(mk(0, 0, 0, 2, 2, 2, 32'hABCD, 32'hABCD, 32'hABCD, 32'hABCD, 32'hABCD), "rst_wr", 3);

    // full sweep of every index
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      w = 32'(i) * 32'h0101_0101;
      reg_write = 1'b1; rd_addr = 5'(i); rd_data = w;
    end
    for (int i = 0; i < 32; i++) begin
      w = 32'(i) * 32'h0101_0101;
      v = mk(0, 0, 0, 5'(i), 5'(31 - i), 5'(i), w, w,
             32'(31 - i) * 32'h0101_0101, 32'(31 - i) * 32'h0101_0101, w);
      apply(v, "sweep", i);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
